layer_2_pool: RTL
=================

# layer_2_pool

2x2 max-pooling stage that sits directly downstream of the second convolution layer. It consumes that layer's post-ReLU stream, one 18-bit sample per valid cycle. Each four consecutive accepted samples form one 2x2 window of one channel. The block reduces each window to its maximum, tags it with a rotating channel index, and buffers results in a small show-ahead FIFO for the following dense stage.

## Interface
Parameters:
- DW, 18, sample and result width (unsigned, non-negative after ReLU)
- CH, 4, number of channels; the channel tag rotates 0..CH-1
- DEPTH, 8, output FIFO entries (power of two)
- N_OUT, 100, pooled results per frame

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- tx_done  in  1  synchronous frame clear; highest priority after reset
- din  in  DW  input sample
- din_vld  in  1  din valid this cycle
- stall  out  DW-independent 1  FIFO full; upstream must hold din_vld low
- dout  out  DW  FIFO head value; 0 when empty
- dout_ch  out  $clog2(CH)  channel tag of head; 0 when empty
- dout_vld  out  1  FIFO non-empty
- dout_ack  in  1  pop head this cycle
- done  out  1  one-cycle pulse after the N_OUT-th result is written
- ovf  out  1  sticky protocol-error flag

## Operation
- **Accept rule:** a sample is accepted when din_vld=1, stall=0 and state=COLLECT.
- **Rejected samples:** din_vld=1 in any other condition drops the sample and sets ovf. ovf stays set until tx_done or reset.
- **Sample counter:** s_cnt is 2 bits, runs 0..3, and advances on each accept.
  - s_cnt=0: max_r <= din.
  - s_cnt=1..2: max_r <= (din > max_r) ? din : max_r. The comparison is unsigned.
  - s_cnt=3: push {max(max_r, din), ch_r} into the FIFO; ch_r <= (ch_r==CH-1) ? 0 : ch_r+1; out_cnt increments.
- **Ties:** equal values keep the existing max_r. The pooled value is unaffected.
- **FIFO occupancy:**
  - stall = (count == DEPTH).
  - Push and pop in the same cycle leave count unchanged when 0 < count < DEPTH.
  - Pop while empty is ignored, and does not set ovf.
  - Pointers wrap modulo DEPTH.
- **State machine:**
  - COLLECT -> DONE when the push that makes out_cnt == N_OUT occurs. done pulses high in the following cycle.
  - DONE: all din_vld is rejected (sets ovf). The FIFO still drains normally.
  - DONE -> COLLECT only on tx_done.
- **tx_done:** clears s_cnt, max_r, ch_r, out_cnt, FIFO pointers/count, ovf and state (-> COLLECT).
  - A same-cycle din_vld or dout_ack is ignored.
  - A partially collected window is discarded.
- **Reset values:** state COLLECT; s_cnt, ch_r, out_cnt, count and max_r are 0. Outputs: stall 0, dout 0, dout_ch 0, dout_vld 0, done 0, ovf 0.

## Timing
- The FIFO write is registered. If the 4th sample is accepted at edge k, the entry is visible with dout_vld=1 after edge k. Latency from the 4th sample to dout_vld is 1 cycle.
- The FIFO is show-ahead: dout and dout_ch are valid whenever dout_vld=1. dout_ack at edge k removes the head, and the next entry (or 0) appears after edge k.
- stall is combinational from registered count, so it changes only after a clock edge. A push at edge k into count DEPTH-1 raises stall after edge k.
- Throughput: one result per 4 accepted samples. Back-to-back din_vld is supported with no bubbles while stall=0.
- done is registered: high for exactly the one cycle after the final push edge.
- rst_n assertion mid-window or mid-frame clears immediately (asynchronous). No partial window survives.

## Test plan
- **Single window:** reset, then din 5,9,3,7 on 4 consecutive cycles. Required: dout_vld=1 one cycle after the 4th sample, dout=9, dout_ch=0. dout_ack then gives dout_vld=0 and dout=0.
- **Channel rotation and ties:** 5 windows of {4,4,4,4}, {1,2,3,4}, {8,0,0,0}, {0,0,0,6}, {2,2,2,2}. Required: results 4,4,8,6,2 with dout_ch 0,1,2,3,0.
- **Full FIFO:** 8 windows with no ack gives stall=1 and count=8. A further din_vld is dropped and sets ovf=1. One dout_ack drops stall after that edge, and ovf stays 1.
- **Simultaneous push/pop:** at count=3, the 4th sample and dout_ack land on the same edge. Required: count stays 3, ordering is preserved, and the popped value is the oldest.
- **Mid-window tx_done:** accept 2 samples (50,60), then tx_done, then 1,2,3,4. Required: a single result 4 with dout_ch=0, and the FIFO previously holding 2 entries is empty after tx_done.
- **Frame completion:** 100 windows with continuous ack. Required: done high for one cycle after the 100th push, and dout_ch of the 100th result = 3. The next din_vld sets ovf and produces no result. After tx_done, a new window is accepted again.

Source files
------------

// File: rtl/layer_2_pool.sv
// 2x2 max-pooling stage: reduces each 4-sample window to its maximum, tags it with a
// rotating channel index and queues it in a show-ahead FIFO for the dense stage.
module layer_2_pool #(
    parameter int unsigned DW    = 18,
    parameter int unsigned CH    = 4,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned N_OUT = 100
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                tx_done,
    input  logic [DW-1:0]                       din,
    input  logic                                din_vld,
    output logic                                stall,
    output logic [DW-1:0]                       dout,
    output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] dout_ch,
    output logic                                dout_vld,
    input  logic                                dout_ack,
    output logic                                done,
    output logic                                ovf
);

    localparam int unsigned CW = (CH > 1) ? $clog2(CH) : 1;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned NW = $clog2(N_OUT + 1);

    typedef enum logic [0:0] {StCollect, StDone} state_e;

    state_e         state;
    logic [1:0]     s_cnt;
    logic [DW-1:0]  max_r;
    logic [CW-1:0]  ch_r;
    logic [NW-1:0]  out_cnt;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;

    logic [DW-1:0]  mem_v [DEPTH];
    logic [CW-1:0]  mem_c [DEPTH];

    logic           accept;
    logic           push;
    logic           pop;
    logic           last;
    logic [DW-1:0]  win_max;

    assign stall   = (count == (AW+1)'(DEPTH));
    assign accept  = din_vld && !stall && (state == StCollect);
    assign push    = accept && (s_cnt == 2'd3);
    assign pop     = dout_ack && (count != '0);
    // Strict compare: a tie keeps the value already held.
    assign win_max = (din > max_r) ? din : max_r;
    assign last    = (out_cnt == NW'(N_OUT - 1));

    assign dout_vld = (count != '0);
    assign dout     = dout_vld ? mem_v[rd_ptr] : '0;
    assign dout_ch  = dout_vld ? mem_c[rd_ptr] : '0;

    // Storage needs no reset: the head is gated by count.
    always_ff @(posedge clk) begin
        if (push && !tx_done) begin
            mem_v[wr_ptr] <= win_max;
            mem_c[wr_ptr] <= ch_r;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= StCollect;
            s_cnt   <= '0;
            max_r   <= '0;
            ch_r    <= '0;
            out_cnt <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            done    <= 1'b0;
            ovf     <= 1'b0;
        end else if (tx_done) begin
            state   <= StCollect;
            s_cnt   <= '0;
            max_r   <= '0;
            ch_r    <= '0;
            out_cnt <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            done    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= push && last;
            if (din_vld && !accept) begin
                ovf <= 1'b1;
            end
            if (accept) begin
                s_cnt <= s_cnt + 2'd1;
                if (s_cnt == 2'd0) begin
                    max_r <= din;
                end else if (s_cnt != 2'd3) begin
                    max_r <= win_max;
                end
            end
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                out_cnt <= out_cnt + 1'b1;
                ch_r    <= (ch_r == CW'(CH - 1)) ? '0 : ch_r + 1'b1;
                if (last) begin
                    state <= StDone;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
